// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the cpu_seq control sequencer.
package cpu_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      EXEC,
      MEMW,
      HALT
   } state_t;

   localparam int OPC_W = 4;
   localparam logic [OPC_W-1:0] HALT_OP_DEFAULT = 4'hF;
   localparam int WAIT_W = 2;

endpackage

// File: rtl/cpu_seq.sv
// Multi-cycle fetch/execute sequencer owning pc, inst and the write strobes.
// Optional single-step launch from IDLE is enabled by defining CPU_SEQ_STEP_EN.
module cpu_seq
   import cpu_seq_pkg::*;
#(
   parameter int PC_W = 7,
   parameter logic [OPC_W-1:0] HALT_OP = HALT_OP_DEFAULT,
   parameter int MEM_WAIT = 0,
   parameter int RESET_PC = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
`ifdef CPU_SEQ_STEP_EN
   input  logic            step,
`endif
   input  logic [15:0]     mem_rdata,
   input  logic            dec_mem_we,
   input  logic            dec_mem_re,
   input  logic            dec_ldi,
   output logic [PC_W-1:0] pc,
   output logic [15:0]     inst,
   output logic            fetch,
   output logic            reg_we,
   output logic            mem_we,
   output logic            busy,
   output logic            halted,
   output logic [15:0]     retired
);

   localparam bit HAS_WAIT = (MEM_WAIT > 0);
   localparam logic [WAIT_W-1:0] WAIT_LOAD = HAS_WAIT ? WAIT_W'(MEM_WAIT - 1) : '0;

   state_t            state_q;
   state_t            state_d;
   logic [WAIT_W-1:0] wait_q;
   logic              complete;
   logic              mem_op;
   logic              ldi_unused;

   // dec_ldi only steers the datapath mux; sequencing never looks at it.
   assign ldi_unused = dec_ldi;
   assign mem_op     = dec_mem_we | dec_mem_re;

`ifdef CPU_SEQ_STEP_EN
   logic step_q;
`endif

   always_comb begin
      state_d  = state_q;
      complete = 1'b0;
      unique case (state_q)
         IDLE: begin
`ifdef CPU_SEQ_STEP_EN
            if (run || step) state_d = FETCH;
`else
            if (run) state_d = FETCH;
`endif
         end
         FETCH:   state_d = (mem_rdata[15:12] == HALT_OP) ? HALT : EXEC;
         EXEC: begin
            if (mem_op && HAS_WAIT) state_d = MEMW;
            else complete = 1'b1;
         end
         MEMW:    if (wait_q == '0) complete = 1'b1;
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
      if (complete) begin
`ifdef CPU_SEQ_STEP_EN
         state_d = (run && !step_q) ? FETCH : IDLE;
`else
         state_d = run ? FETCH : IDLE;
`endif
      end
   end

   // Strobes are masked by rst so an instruction interrupted by reset never writes.
   assign fetch  = !rst && (state_q == FETCH);
   assign busy   = !rst && ((state_q == FETCH) || (state_q == EXEC) || (state_q == MEMW));
   assign halted = !rst && (state_q == HALT);
   assign mem_we = !rst && complete && dec_mem_we;
   assign reg_we = !rst && complete && !dec_mem_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc      <= PC_W'(RESET_PC);
         inst    <= '0;
         retired <= '0;
         wait_q  <= '0;
`ifdef CPU_SEQ_STEP_EN
         step_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (state_q == FETCH) begin
            inst <= mem_rdata;
            if (state_d == EXEC) pc <= pc + PC_W'(1);
         end
         if (state_q == EXEC) wait_q <= WAIT_LOAD;
         else if (state_q == MEMW) wait_q <= wait_q - WAIT_W'(1);
         if (complete) retired <= retired + 16'd1;
`ifdef CPU_SEQ_STEP_EN
         if ((state_q == IDLE) && (state_d == FETCH)) step_q <= !run;
`endif
      end
   end

endmodule

// File: tb/tb_cpu_seq.sv
// Bench for cpu_seq: three instances (MEM_WAIT 0/2/1, RESET_PC 0/127/0) checked
// each cycle against an instruction-level model, plus directed literal checks.
module tb_cpu_seq;

   localparam int N = 3;

   logic        clk;
   logic        rst_v    [N];
   logic        run_v    [N];
`ifdef CPU_SEQ_STEP_EN
   logic        step_v   [N];
`endif
   logic [15:0] rdata_v  [N];
   logic        we_flag  [N];
   logic        re_flag  [N];
   logic        ldi_flag [N];
   logic [6:0]  pc_o     [N];
   logic [15:0] inst_o   [N];
   logic [15:0] ret_o    [N];
   logic        fetch_o  [N];
   logic        reg_we_o [N];
   logic        mem_we_o [N];
   logic        busy_o   [N];
   logic        halted_o [N];

   logic [15:0] mem [N][128];

   // Model: mode 0 idle, 1 fetching, 2 executing (m_left cycles to completion), 3 halted.
   int          m_mode [N];
   int          m_left [N];
   int          m_pc   [N];
   int          m_ret  [N];
   logic [15:0] m_inst [N];
   bit          m_step [N];

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      assign rdata_v[g] = mem[g][pc_o[g]];
      cpu_seq #(
         .MEM_WAIT ((g == 1) ? 2 : ((g == 2) ? 1 : 0)),
         .RESET_PC ((g == 1) ? 127 : 0)
      ) u_dut (
         .clk        (clk),
         .rst        (rst_v[g]),
         .run        (run_v[g]),
`ifdef CPU_SEQ_STEP_EN
         .step       (step_v[g]),
`endif
         .mem_rdata  (rdata_v[g]),
         .dec_mem_we (we_flag[g]),
         .dec_mem_re (re_flag[g]),
         .dec_ldi    (ldi_flag[g]),
         .pc         (pc_o[g]),
         .inst       (inst_o[g]),
         .fetch      (fetch_o[g]),
         .reg_we     (reg_we_o[g]),
         .mem_we     (mem_we_o[g]),
         .busy       (busy_o[g]),
         .halted     (halted_o[g]),
         .retired    (ret_o[g])
      );
   end

   function automatic int wait_of(int k);
      return (k == 1) ? 2 : ((k == 2) ? 1 : 0);
   endfunction

   function automatic int rpc_of(int k);
      return (k == 1) ? 127 : 0;
   endfunction

   function automatic bit is_store(logic [15:0] w);
      return (w[15:12] == 4'hA) || (w[15:12] == 4'hC);
   endfunction

   function automatic bit is_load(logic [15:0] w);
      return (w[15:12] == 4'hB) || (w[15:12] == 4'hC);
   endfunction

   function automatic logic [15:0] rand_word(int halt_pct);
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      if (int'($urandom_range(0, 99)) < halt_pct) op = 4'hF;
      return {op, 12'($urandom)};
   endfunction

   task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, k, act, exp, $time);
      end
   endtask

   // Reference model advances on the same edge as the DUTs.
   always @(posedge clk) begin
      for (int k = 0; k < N; k++) begin
         bit step_in;
         logic [15:0] w;
         step_in = 1'b0;
`ifdef CPU_SEQ_STEP_EN
         step_in = step_v[k];
`endif
         if (rst_v[k]) begin
            m_mode[k] = 0;
            m_pc[k]   = rpc_of(k);
            m_inst[k] = 16'h0;
            m_ret[k]  = 0;
            m_step[k] = 1'b0;
         end else begin
            case (m_mode[k])
               0: begin
                  if (run_v[k]) begin
                     m_mode[k] = 1;
                     m_step[k] = 1'b0;
                  end else if (step_in) begin
                     m_mode[k] = 1;
                     m_step[k] = 1'b1;
                  end
               end
               1: begin
                  w = mem[k][m_pc[k]];
                  m_inst[k] = w;
                  if (w[15:12] == 4'hF) m_mode[k] = 3;
                  else begin
                     m_pc[k]   = (m_pc[k] + 1) % 128;
                     m_mode[k] = 2;
                     m_left[k] = (is_store(w) || is_load(w)) ? 1 + wait_of(k) : 1;
                  end
               end
               2: begin
                  if (m_left[k] == 1) begin
                     m_ret[k]  = (m_ret[k] + 1) % 65536;
                     m_mode[k] = (run_v[k] && !m_step[k]) ? 1 : 0;
                  end else begin
                     m_left[k] = m_left[k] - 1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < N; k++) begin
            bit live;
            bit done;
            bit st;
            live = !rst_v[k];
            done = (m_mode[k] == 2) && (m_left[k] == 1);
            st   = is_store(m_inst[k]);
            check("fetch",   k, 32'(fetch_o[k]),  32'(live && (m_mode[k] == 1)));
            check("busy",    k, 32'(busy_o[k]),   32'(live && (m_mode[k] == 1 || m_mode[k] == 2)));
            check("halted",  k, 32'(halted_o[k]), 32'(live && (m_mode[k] == 3)));
            check("reg_we",  k, 32'(reg_we_o[k]), 32'(live && done && !st));
            check("mem_we",  k, 32'(mem_we_o[k]), 32'(live && done && st));
            check("pc",      k, 32'(pc_o[k]),     32'(m_pc[k]));
            check("inst",    k, 32'(inst_o[k]),   32'(m_inst[k]));
            check("retired", k, 32'(ret_o[k]),    32'(m_ret[k]));
         end
      end
   end

   // Decoder stand-in: true flags while the model executes, noise everywhere else.
   task automatic cyc();
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         if (m_mode[k] == 2) begin
            we_flag[k] = is_store(m_inst[k]);
            re_flag[k] = is_load(m_inst[k]);
         end else begin
            we_flag[k] = 1'($urandom_range(0, 1));
            re_flag[k] = 1'($urandom_range(0, 1));
         end
         ldi_flag[k] = 1'($urandom_range(0, 1));
      end
   endtask

   initial begin
      for (int k = 0; k < N; k++) begin
         rst_v[k]    = 1'b1;
         run_v[k]    = 1'b0;
         we_flag[k]  = 1'b0;
         re_flag[k]  = 1'b0;
         ldi_flag[k] = 1'b0;
`ifdef CPU_SEQ_STEP_EN
         step_v[k]   = 1'b0;
`endif
         for (int i = 0; i < 128; i++) mem[k][i] = rand_word(0);
      end
      mem[0][0]   = 16'h1234;
      mem[0][5]   = 16'hF000;
      mem[1][127] = 16'hA000;
      mem[2][0]   = 16'hB000;

      cyc();
      cyc();
      chk_en = 1'b1;
      @(negedge clk);
      check("lit_reset_pc_a",  0, 32'(pc_o[0]),   32'd0);
      check("lit_reset_pc_b",  1, 32'(pc_o[1]),   32'd127);
      check("lit_reset_inst",  0, 32'(inst_o[0]), 32'd0);
      check("lit_reset_ret",   0, 32'(ret_o[0]),  32'd0);

      cyc();
      for (int k = 0; k < N; k++) begin
         rst_v[k] = 1'b0;
         run_v[k] = 1'b1;
      end
      cyc();
      @(negedge clk);
      check("lit_c1_fetch",    0, 32'(fetch_o[0]),  32'd1);
      cyc();
      run_v[2] = 1'b0;
      @(negedge clk);
      check("lit_c2_inst",     0, 32'(inst_o[0]),   32'h1234);
      check("lit_c2_pc",       0, 32'(pc_o[0]),     32'd1);
      check("lit_c2_reg_we",   0, 32'(reg_we_o[0]), 32'd1);
      check("lit_wrap_pc",     1, 32'(pc_o[1]),     32'd0);
      check("lit_store_exec",  1, 32'(mem_we_o[1]), 32'd0);
      cyc();
      @(negedge clk);
      check("lit_c3_retired",  0, 32'(ret_o[0]),    32'd1);
      check("lit_c3_fetch",    0, 32'(fetch_o[0]),  32'd1);
      check("lit_memw1",       1, 32'(mem_we_o[1]), 32'd0);
      check("lit_load_reg_we", 2, 32'(reg_we_o[2]), 32'd1);
      cyc();
      @(negedge clk);
      check("lit_store_we",    1, 32'(mem_we_o[1]), 32'd1);
      check("lit_store_noreg", 1, 32'(reg_we_o[1]), 32'd0);
      check("lit_drop_idle",   2, 32'(busy_o[2]),   32'd0);
      check("lit_drop_pc",     2, 32'(pc_o[2]),     32'd1);
      cyc();
      run_v[2] = 1'b1;
      cyc();
      @(negedge clk);
      check("lit_resume_fetch", 2, 32'(fetch_o[2]), 32'd1);
      check("lit_resume_pc",    2, 32'(pc_o[2]),    32'd1);

      repeat (30) cyc();
      @(negedge clk);
      check("lit_halted",      0, 32'(halted_o[0]), 32'd1);
      check("lit_halt_pc",     0, 32'(pc_o[0]),     32'd5);
      check("lit_halt_ret",    0, 32'(ret_o[0]),    32'd5);
      cyc();
      rst_v[0] = 1'b1;
      @(negedge clk);
      check("lit_rst_halted",  0, 32'(halted_o[0]), 32'd0);
      cyc();
      rst_v[0] = 1'b0;
      run_v[0] = 1'b0;
      @(negedge clk);
      check("lit_post_halt_pc", 0, 32'(pc_o[0]),    32'd0);

      cyc();
      rst_v[1] = 1'b1;
      cyc();
      rst_v[1] = 1'b0;
      run_v[1] = 1'b1;
      repeat (4) cyc();
      rst_v[1] = 1'b1;
      @(negedge clk);
      check("lit_rst_memw_we", 1, 32'(mem_we_o[1]), 32'd0);
      cyc();
      rst_v[1] = 1'b0;
      run_v[1] = 1'b0;
      @(negedge clk);
      check("lit_rst_idle",    1, 32'(busy_o[1]),   32'd0);
      check("lit_rst_ret",     1, 32'(ret_o[1]),    32'd0);
      check("lit_rst_pc",      1, 32'(pc_o[1]),     32'd127);

      for (int k = 0; k < N; k++)
         for (int i = 0; i < 128; i++) mem[k][i] = rand_word(2);
      repeat (3000) begin
         cyc();
         for (int k = 0; k < N; k++) begin
            rst_v[k] = ($urandom_range(0, 199) == 0);
            run_v[k] = ($urandom_range(0, 9) != 0);
`ifdef CPU_SEQ_STEP_EN
            step_v[k] = ($urandom_range(0, 3) == 0);
`endif
         end
      end
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_seq.md
Name: cpu_seq

Overview:
- Multi-cycle control sequencer for the 8-bit CPU datapath: register file, ALU, instruction decoder, and 128x16 word-addressed memory.
- Replaces the free-running fetch/execute toggle with an FSM. The FSM owns the program counter and the instruction register, and drives the fetch address-mux select.
- It gates the register-file and memory write strobes, and inserts wait states for data-memory accesses.
- It stops on a HALT opcode and counts retired instructions.

Parameters:
- PC_W, 7: program-counter width in words; the fetch byte address is {pc,1'b0}.
- HALT_OP, 4'hF: value of inst[15:12] that halts the core.
- MEM_WAIT, 0: extra cycles added to load/store instructions; legal range 0..3.
- RESET_PC, 0: pc value after reset.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; while high, the sequencer keeps executing instructions.
- mem_rdata  in  16  memory read word (asynchronous read, same cycle).
- dec_mem_we  in  1  decoder store flag for the current inst[15:12].
- dec_mem_re  in  1  decoder load flag.
- dec_ldi  in  1  decoder load-immediate flag; datapath mux only, no effect on sequencing.
- pc  out  PC_W  program counter.
- inst  out  16  instruction register; feeds decoder and register-file addresses.
- fetch  out  1  high in FETCH; selects {pc,0} as the memory address.
- reg_we  out  1  register-file write strobe.
- mem_we  out  1  memory write strobe.
- busy  out  1  high in FETCH, EXEC and MEMW.
- halted  out  1  high in HALT.
- retired  out  16  count of completed instructions; wraps.

Behaviour:
- Reset:
  - state=IDLE, pc=RESET_PC, inst=0, retired=0.
  - While rst=1, fetch, reg_we, mem_we, busy and halted are forced to 0 combinationally.
  - rst wins over every other event, including a reset mid-instruction; the interrupted instruction is abandoned with no strobe.
- Registered state; strobes are decoded combinationally from state and decoder flags.
- IDLE: all strobes 0. run=1 -> FETCH next cycle.
- FETCH (1 cycle): fetch=1.
  - If mem_rdata[15:12]==HALT_OP: inst<=mem_rdata, pc unchanged, go to HALT.
  - Otherwise: inst<=mem_rdata, pc<=pc+1 (wrap at 2^PC_W to 0), go to EXEC.
- EXEC:
  - A memory op is dec_mem_we|dec_mem_re.
  - Memory op with MEM_WAIT>0: load wait counter with MEM_WAIT-1, go to MEMW, no strobe this cycle.
  - Otherwise this is the completion cycle.
- MEMW: decrement the counter; the cycle in which the counter is 0 is the completion cycle.
- Completion cycle:
  - Store (dec_mem_we=1): mem_we=1, reg_we=0.
  - Any other instruction: reg_we=1, mem_we=0.
  - retired<=retired+1.
  - Next state is FETCH if run=1, else IDLE.
- Strobes are high for exactly one cycle per instruction, and never in FETCH.
- Instruction latency: 2 cycles, or 2+MEM_WAIT for loads and stores.
- Both dec_mem_we and dec_mem_re set: treated as a store.
- run dropped mid-instruction: the current instruction completes, then IDLE. pc and inst are held; raising run again resumes at pc.
- HALT: halted=1, all strobes 0, run ignored. Only rst exits HALT.
- Decoder flags are sampled only in EXEC/MEMW and are ignored elsewhere.

Optional Feature:
- Macro: CPU_SEQ_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - In IDLE, a step=1 cycle starts one instruction even if run=0.
  - A step-launched instruction returns to IDLE after completion regardless of run.
  - step is ignored outside IDLE.
- Undefined: no step port; only run launches execution.

Decomposition:
- Package cpu_seq_pkg:
  - state enum {IDLE, FETCH, EXEC, MEMW, HALT}
  - OPC_W=4 and the default HALT_OP constant
  - wait-counter width (2 bits)
- No sub-module. The FSM, pc/inst registers, wait counter and retired counter live in one module; each is too small to justify splitting.

Test Plan:
- Basic instruction:
  - Stimulus: rst, then run=1; mem_rdata=16'h1234; all decoder flags 0.
  - Response: cycle 1 fetch=1. Cycle 2 inst=16'h1234, pc=1, reg_we=1. Cycle 3 retired=1 and FETCH again.
- Store with wait states:
  - Stimulus: MEM_WAIT=2, dec_mem_we=1.
  - Response: EXEC then 2 MEMW cycles; mem_we=1 only in the final MEMW cycle; reg_we=0 throughout; 4 cycles per instruction.
- HALT:
  - Stimulus: mem_rdata=16'hF000 fetched at pc=5.
  - Response: halted=1, pc stays 5, no strobes for 20 cycles with run=1, retired unchanged; rst returns to IDLE with pc=0.
- PC wrap:
  - Stimulus: RESET_PC=127, fetch a non-halt instruction.
  - Response: pc=0 after FETCH.
- run dropped:
  - Stimulus: run=0 during EXEC of a load with MEM_WAIT=1.
  - Response: reg_we pulses once, then IDLE with busy=0; re-assert run -> FETCH at the held pc.
- Reset mid-operation:
  - Stimulus: rst=1 in the final MEMW cycle of a store.
  - Response: mem_we=0 that cycle; next cycle state=IDLE, retired=0.
